captura_digitos: RTL

- Keypad entry stage that sits directly upstream of the save/sum stage (Guardado_datos).
- Takes one 4-bit key code per key press and shifts decimal digits into a 4-digit BCD operand.
- Supports clear and backspace keys.
- On the enter key, emits the single-cycle `guardar` pulse consumed downstream.
- Clears its operand when the downstream stage returns `rst_dat`.

---
 rtl/teclado_pkg.sv | 26 ++
 rtl/detector_pulsacion.sv | 41 ++++
 rtl/captura_digitos.sv | 86 ++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// Shared keypad definitions: BCD digit and operand types, key codes and the
// key-press FSM states. Also used by the save stage and the adder.
package teclado_pkg;

   localparam int unsigned N_DIG = 4;
   localparam int unsigned CNT_W = 3;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [N_DIG-1:0] operando_t;

   localparam bcd_t MAX_DIGITO   = 4'h9;
   localparam bcd_t TECLA_ENTER  = 4'hA;
   localparam bcd_t TECLA_BORRAR = 4'hB;
   localparam bcd_t TECLA_RETRO  = 4'hC;

   // Key-press FSM states (plain constants so older blocks can share them)
   typedef logic [0:0] estado_tecla_e;
   localparam estado_tecla_e LIBRE    = 1'b0;
   localparam estado_tecla_e RETENIDO = 1'b1;

   // Key codes 0..9 are decimal digits
   function automatic logic es_digito(input bcd_t t);
      return (t <= MAX_DIGITO);
   endfunction

endpackage

// File: rtl/detector_pulsacion.sv
// Press detector: turns the level tecla_valida into a single-cycle accept
// strobe, so a key held for any number of cycles acts exactly once.
//   clk, rst      : clock, synchronous active-high reset
//   tecla_valida  : key held level from the keypad scanner
//   acepta_c      : combinational strobe, high on the edge that accepts a press
module detector_pulsacion
   import teclado_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tecla_valida,
   output logic acepta_c
);

   estado_tecla_e estado, estado_sig;

   // State register; rst wins even while a key is held
   always_ff @(posedge clk) begin
      if (rst) estado <= LIBRE;
      else     estado <= estado_sig;
   end

   // Next state and accept strobe
   always_comb begin
      estado_sig = estado;
      acepta_c   = 1'b0;
      case (estado)
         LIBRE: begin
            if (tecla_valida) begin
               acepta_c   = 1'b1;
               estado_sig = RETENIDO;
            end
         end
         RETENIDO: begin
            if (!tecla_valida) estado_sig = LIBRE;
         end
         default: estado_sig = LIBRE;
      endcase
   end

endmodule

// File: rtl/captura_digitos.sv
// Keypad entry stage: shifts BCD digits into a 4-digit operand, supports
// clear/backspace, and pulses guardar on enter for the downstream save stage.
//   clk, rst      : clock, synchronous active-high reset
//   tecla         : key code, valid while tecla_valida=1
//   tecla_valida  : key held level
//   rst_dat       : clear request from the save stage
//   numero        : operand, [0] is the least significant digit
//   num_digitos   : digits entered, 0..N_DIG
//   lleno         : num_digitos == N_DIG
//   guardar       : one-cycle pulse after an accepted enter
module captura_digitos
   import teclado_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            tecla,
   input  logic                  tecla_valida,
   input  logic                  rst_dat,
   output logic [N_DIG-1:0][3:0] numero,
   output logic [2:0]            num_digitos,
   output logic                  lleno,
   output logic                  guardar
);

   logic             acepta_c;
   operando_t        numero_d;
   logic [CNT_W-1:0] cnt_d;
   logic             guardar_d;

   detector_pulsacion u_detector (
      .clk          (clk),
      .rst          (rst),
      .tecla_valida (tecla_valida),
      .acepta_c     (acepta_c)
   );

   assign lleno = (num_digitos == CNT_W'(N_DIG));

   // Key decode; rst_dat overrides the data effect but not the enter pulse
   always_comb begin
      numero_d  = numero;
      cnt_d     = num_digitos;
      guardar_d = 1'b0;
      if (acepta_c) begin
         if (es_digito(tecla)) begin
            if (!lleno) begin
               numero_d = {numero[N_DIG-2:0], tecla};
               cnt_d    = num_digitos + CNT_W'(1);
            end
         end else begin
            case (tecla)
               TECLA_RETRO: begin
                  if (num_digitos != '0) begin
                     numero_d = {4'h0, numero[N_DIG-1:1]};
                     cnt_d    = num_digitos - CNT_W'(1);
                  end
               end
               TECLA_BORRAR: begin
                  numero_d = '0;
                  cnt_d    = '0;
               end
               TECLA_ENTER: guardar_d = 1'b1;
               default: ;
            endcase
         end
      end
      if (rst_dat) begin
         numero_d = '0;
         cnt_d    = '0;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         numero      <= '0;
         num_digitos <= '0;
         guardar     <= 1'b0;
      end else begin
         numero      <= numero_d;
         num_digitos <= cnt_d;
         guardar     <= guardar_d;
      end
   end

endmodule
